// File: rtl/note_effect_sequencer.sv
// note_effect_sequencer: programmable step sequencer for the music effects
// datapath. Plays a table of STEPS entries, each with a tone divider, an
// effect selection and a duration in beats. It produces the tone square wave
// (effects clk1), the tremolo LFO square wave (effects clk2) and the
// per-step effect enables. Every output is driven straight from a register.
module note_effect_sequencer #(
    parameter int ADDR_W   = 3,
    parameter int DIV_W    = 12,
    parameter int BEAT_W   = 16,
    parameter int TREM_DIV = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DIV_W+3:0]  wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [BEAT_W-1:0] beat_len,
    output logic              tone_o,
    output logic              lfo_o,
    output logic              octave_dena_o,
    output logic              octave_uena_o,
    output logic              tremolo_ena_o,
    output logic              busy,
    output logic [ADDR_W-1:0] step_o,
    output logic              done
);

    localparam int STEPS = 2 ** ADDR_W;
    localparam int LFO_W = (TREM_DIV > 1) ? $clog2(TREM_DIV) : 1;
    localparam logic [LFO_W-1:0]  LFO_LAST  = LFO_W'(TREM_DIV - 1);
    localparam logic [ADDR_W-1:0] STEP_LAST = '1;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

    state_t              state_q, state_d;
    logic [DIV_W+3:0]    table_q [STEPS];
    logic [ADDR_W-1:0]   step_q, step_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [1:0]          eff_q, eff_d;
    logic [1:0]          dur_q, dur_d;
    logic [DIV_W-1:0]    tcnt_q, tcnt_d;
    logic [LFO_W-1:0]    lcnt_q, lcnt_d;
    logic [BEAT_W-1:0]   bcnt_q, bcnt_d;
    logic [1:0]          beats_q, beats_d;
    logic                tone_q, tone_d;
    logic                lfo_q, lfo_d;
    logic                od_q, od_d;
    logic                ou_q, ou_d;
    logic                tr_q, tr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DIV_W+3:0]    entry;
    logic [DIV_W-1:0]    entry_div;
    logic [1:0]          entry_eff;
    logic [BEAT_W-1:0]   bl_last;
    logic                go_idle;
    logic                step_end;

    // Step table: written at any time, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) table_q[i] <= '0;
        end else if (wr_en) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            div_q   <= '0;
            eff_q   <= '0;
            dur_q   <= '0;
            tcnt_q  <= '0;
            lcnt_q  <= '0;
            bcnt_q  <= '0;
            beats_q <= '0;
            tone_q  <= 1'b0;
            lfo_q   <= 1'b0;
            od_q    <= 1'b0;
            ou_q    <= 1'b0;
            tr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            div_q   <= div_d;
            eff_q   <= eff_d;
            dur_q   <= dur_d;
            tcnt_q  <= tcnt_d;
            lcnt_q  <= lcnt_d;
            bcnt_q  <= bcnt_d;
            beats_q <= beats_d;
            tone_q  <= tone_d;
            lfo_q   <= lfo_d;
            od_q    <= od_d;
            ou_q    <= ou_d;
            tr_q    <= tr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counters and registered-output decode.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        div_d    = div_q;
        eff_d    = eff_q;
        dur_d    = dur_q;
        tcnt_d   = tcnt_q;
        lcnt_d   = lcnt_q;
        bcnt_d   = bcnt_q;
        beats_d  = beats_q;
        tone_d   = tone_q;
        lfo_d    = lfo_q;
        od_d     = od_q;
        ou_d     = ou_q;
        tr_d     = tr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        go_idle  = 1'b0;
        step_end = 1'b0;

        entry     = table_q[step_q];
        entry_div = entry[DIV_W-1:0];
        entry_eff = entry[DIV_W+1:DIV_W];
        // A beat length of zero behaves as one cycle per beat.
        bl_last   = (beat_len == '0) ? '0 : beat_len - 1'b1;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = LOAD;
                    step_d  = '0;
                    busy_d  = 1'b1;
                end
            end

            LOAD: begin
                if (stop) begin
                    go_idle = 1'b1;
                end else begin
                    div_d   = entry_div;
                    eff_d   = entry_eff;
                    dur_d   = entry[DIV_W+3:DIV_W+2];
                    tcnt_d  = '0;
                    lcnt_d  = '0;
                    bcnt_d  = '0;
                    beats_d = '0;
                    tone_d  = 1'b0;
                    lfo_d   = 1'b0;
                    // Rests carry no effect.
                    od_d    = (entry_div != '0) && (entry_eff == 2'b01);
                    ou_d    = (entry_div != '0) && (entry_eff == 2'b10);
                    tr_d    = (entry_div != '0) && (entry_eff == 2'b11);
                    state_d = PLAY;
                end
            end

            PLAY: begin
                if (stop) begin
                    go_idle = 1'b1;
                end else begin
                    if (div_q != '0) begin
                        if (tcnt_q == div_q - 1'b1) begin
                            tcnt_d = '0;
                            tone_d = ~tone_q;
                        end else begin
                            tcnt_d = tcnt_q + 1'b1;
                        end
                    end

                    if (lcnt_q == LFO_LAST) begin
                        lcnt_d = '0;
                        lfo_d  = ~lfo_q;
                    end else begin
                        lcnt_d = lcnt_q + 1'b1;
                    end

                    // >= keeps the beat counter sane if beat_len shrinks mid-beat.
                    if (bcnt_q >= bl_last) begin
                        bcnt_d = '0;
                        if (beats_q == dur_q) begin
                            step_end = 1'b1;
                        end else begin
                            beats_d = beats_q + 1'b1;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end

                    if (step_end) begin
                        tone_d = 1'b0;
                        lfo_d  = 1'b0;
                        od_d   = 1'b0;
                        ou_d   = 1'b0;
                        tr_d   = 1'b0;
                        if (step_q != STEP_LAST) begin
                            step_d  = step_q + 1'b1;
                            state_d = LOAD;
                        end else if (loop_en) begin
                            step_d  = '0;
                            state_d = LOAD;
                        end else begin
                            step_d  = '0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort: silence everything on the same edge, no done pulse.
        if (go_idle) begin
            state_d = IDLE;
            step_d  = '0;
            tone_d  = 1'b0;
            lfo_d   = 1'b0;
            od_d    = 1'b0;
            ou_d    = 1'b0;
            tr_d    = 1'b0;
            busy_d  = 1'b0;
        end
    end

    assign tone_o        = tone_q;
    assign lfo_o         = lfo_q;
    assign octave_dena_o = od_q;
    assign octave_uena_o = ou_q;
    assign tremolo_ena_o = tr_q;
    assign busy          = busy_q;
    assign step_o        = step_q;
    assign done          = done_q;

endmodule

// File: tb/tb_note_effect_sequencer.sv
// Bench for note_effect_sequencer: a table of single-step vectors measured on
// step 0, followed by hand-written sequences for full runs, looping, stop,
// start/stop collisions, live table rewrites and reset mid-playback.
module tb_note_effect_sequencer;

    localparam int ADDR_W = 3;
    localparam int DIV_W  = 12;
    localparam int BEAT_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DIV_W+3:0]  wr_data = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop_en = 1'b0;
    logic [BEAT_W-1:0] beat_len = '0;
    logic              tone_o, lfo_o, octave_dena_o, octave_uena_o, tremolo_ena_o;
    logic              busy, done;
    logic [ADDR_W-1:0] step_o;

    int errors = 0;
    int checks = 0;

    note_effect_sequencer #(
        .ADDR_W(ADDR_W), .DIV_W(DIV_W), .BEAT_W(BEAT_W), .TREM_DIV(64)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .stop(stop), .loop_en(loop_en),
        .beat_len(beat_len), .tone_o(tone_o), .lfo_o(lfo_o),
        .octave_dena_o(octave_dena_o), .octave_uena_o(octave_uena_o),
        .tremolo_ena_o(tremolo_ena_o), .busy(busy), .step_o(step_o),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int div; int eff; int dur; int bl;
        int cyc; int tone_hi; int lfo_hi; int od; int ou; int tr;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_entry(input int addr, input int div, input int eff, input int dur);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = {2'(dur), 2'(eff), 12'(div)};
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Accumulates activity while the given step is current (LOAD + PLAY).
    task automatic count_step(input int s, output int cyc, output int th, output int lh,
                              output int od, output int ou, output int tr);
        cyc = 0; th = 0; lh = 0; od = 0; ou = 0; tr = 0;
        for (int n = 0; n < 400; n++) begin
            if (!(busy && step_o == ADDR_W'(s))) break;
            cyc++;
            th += int'(tone_o);
            lh += int'(lfo_o);
            od += int'(octave_dena_o);
            ou += int'(octave_uena_o);
            tr += int'(tremolo_ena_o);
            @(negedge clk);
            wr_en = 1'b0;
        end
    endtask

    task automatic wait_step(input int s);
        int found;
        found = 0;
        for (int n = 0; n < 600; n++) begin
            if (busy && step_o == ADDR_W'(s)) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("wait_step_reached", found, 1);
    endtask

    vec_t vecs [7];

    initial begin
        int cyc, th, lh, od, ou, tr;
        int nbusy, ndone, done_at, first_busy;

        vecs[0] = '{div:3, eff:0, dur:0, bl:12, cyc:13, tone_hi:6,  lfo_hi:0,  od:0, ou:0, tr:0};
        vecs[1] = '{div:5, eff:3, dur:1, bl:4,  cyc:9,  tone_hi:3,  lfo_hi:0,  od:0, ou:0, tr:8};
        vecs[2] = '{div:2, eff:1, dur:0, bl:5,  cyc:6,  tone_hi:2,  lfo_hi:0,  od:5, ou:0, tr:0};
        vecs[3] = '{div:1, eff:2, dur:2, bl:2,  cyc:7,  tone_hi:3,  lfo_hi:0,  od:0, ou:6, tr:0};
        vecs[4] = '{div:0, eff:3, dur:1, bl:3,  cyc:7,  tone_hi:0,  lfo_hi:0,  od:0, ou:0, tr:0};
        vecs[5] = '{div:4, eff:0, dur:0, bl:0,  cyc:2,  tone_hi:0,  lfo_hi:0,  od:0, ou:0, tr:0};
        vecs[6] = '{div:7, eff:3, dur:3, bl:20, cyc:81, tone_hi:38, lfo_hi:16, od:0, ou:0, tr:80};

        // Reset values
        do_reset();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_step", int'(step_o), 0);
        chk("rst_tone", int'(tone_o), 0);
        chk("rst_lfo", int'(lfo_o), 0);
        chk("rst_enables", int'({octave_dena_o, octave_uena_o, tremolo_ena_o}), 0);

        // Table-driven single-step measurements on step 0
        for (int v = 0; v < 7; v++) begin
            write_entry(0, vecs[v].div, vecs[v].eff, vecs[v].dur);
            beat_len = BEAT_W'(vecs[v].bl);
            loop_en  = 1'b0;
            pulse_start();
            chk($sformatf("v%0d_busy_after_start", v), int'(busy), 1);
            count_step(0, cyc, th, lh, od, ou, tr);
            chk($sformatf("v%0d_step0_cycles", v), cyc, vecs[v].cyc);
            chk($sformatf("v%0d_tone_high", v), th, vecs[v].tone_hi);
            chk($sformatf("v%0d_lfo_high", v), lh, vecs[v].lfo_hi);
            chk($sformatf("v%0d_octd_high", v), od, vecs[v].od);
            chk($sformatf("v%0d_octu_high", v), ou, vecs[v].ou);
            chk($sformatf("v%0d_trem_high", v), tr, vecs[v].tr);
            chk($sformatf("v%0d_step1_enables_in_load", v),
                int'({octave_dena_o, octave_uena_o, tremolo_ena_o}), 0);
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            chk($sformatf("v%0d_idle_after_stop", v), int'(busy), 0);
        end

        // Full non-looped run: 8 steps of 13 cycles, single done pulse
        do_reset();
        write_entry(0, 3, 0, 0);
        beat_len = 16'd12;
        loop_en  = 1'b0;
        pulse_start();
        nbusy = 0; ndone = 0; done_at = -1; first_busy = int'(busy);
        for (int k = 0; k < 120; k++) begin
            nbusy += int'(busy);
            if (done) begin
                ndone++;
                done_at = k;
                chk("run_busy_low_at_done", int'(busy), 0);
                chk("run_step_zero_at_done", int'(step_o), 0);
            end
            @(negedge clk);
        end
        chk("run_first_busy", first_busy, 1);
        chk("run_busy_cycles", nbusy, 104);
        chk("run_done_pulses", ndone, 1);
        chk("run_done_cycle", done_at, 104);

        // Looping with beat_len=0, extra start ignored, stop mid-PLAY
        do_reset();
        for (int a = 0; a < 8; a++) write_entry(a, 1, 3, 0);
        beat_len = '0;
        loop_en  = 1'b1;
        pulse_start();
        ndone = 0;
        for (int k = 0; k < 21; k++) begin
            chk($sformatf("loop_step_k%0d", k), int'(step_o), (k / 2) % 8);
            chk($sformatf("loop_trem_k%0d", k), int'(tremolo_ena_o), k % 2);
            ndone += int'(done);
            start = (k == 5);
            @(negedge clk);
        end
        start = 1'b0;
        chk("loop_no_done", ndone, 0);
        chk("loop_in_play_before_stop", int'(tremolo_ena_o), 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_trem", int'(tremolo_ena_o), 0);
        chk("stop_tone", int'(tone_o), 0);
        chk("stop_step", int'(step_o), 0);
        chk("stop_no_done", int'(done), 0);
        @(negedge clk);
        chk("stop_still_idle", int'(busy), 0);
        chk("stop_no_done_later", int'(done), 0);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_busy", int'(busy), 0);
        @(negedge clk);
        chk("startstop_busy_later", int'(busy), 0);

        // Rewrite of the playing step, then reset mid-PLAY
        do_reset();
        write_entry(3, 2, 0, 0);
        beat_len = 16'd6;
        loop_en  = 1'b1;
        pulse_start();
        wait_step(3);
        wr_en   = 1'b1;
        wr_addr = 3'd3;
        wr_data = {2'd0, 2'd0, 12'd1};
        count_step(3, cyc, th, lh, od, ou, tr);
        chk("rewrite_old_cycles", cyc, 7);
        chk("rewrite_old_tone", th, 2);
        wait_step(3);
        count_step(3, cyc, th, lh, od, ou, tr);
        chk("rewrite_new_tone", th, 3);
        wait_step(3);
        @(negedge clk);
        @(negedge clk);
        chk("midplay_tone_high", int'(tone_o), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_tone", int'(tone_o), 0);
        chk("rst_mid_step", int'(step_o), 0);
        chk("rst_mid_done", int'(done), 0);
        rst     = 1'b0;
        loop_en = 1'b0;
        @(negedge clk);
        pulse_start();
        wait_step(3);
        count_step(3, cyc, th, lh, od, ou, tr);
        chk("cleared_step3_cycles", cyc, 7);
        chk("cleared_step3_tone", th, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/note_effect_sequencer.md
Name: note_effect_sequencer

Overview:
- Programmable step sequencer that drives the music effects datapath.
- Generates the tone square wave (feeds effects clk1) and the tremolo LFO square wave (feeds effects clk2).
- Drives the octave-down, octave-up and tremolo enables per step.
- Plays a table of up to 2**ADDR_W steps, each with its own pitch, effect and duration, once or looped.

Parameters:
ADDR_W, 3, step-table address width; table depth STEPS = 2**ADDR_W
DIV_W, 12, tone half-period divider width
BEAT_W, 16, beat-length counter width
TREM_DIV, 64, LFO half-period in clk cycles (>=1)

Ports:
clk  in  1  single system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  write step-table entry this cycle
wr_addr  in  ADDR_W  entry index
wr_data  in  DIV_W+4  [DIV_W-1:0] tone half-period divider (0 = rest); [DIV_W+1:DIV_W] effect (00 none, 01 octave down, 10 octave up, 11 tremolo); [DIV_W+3:DIV_W+2] duration in beats minus 1
start  in  1  begin playback at step 0 (pulse)
stop  in  1  abort playback (pulse)
loop_en  in  1  wrap from last step to step 0 instead of finishing
beat_len  in  BEAT_W  cycles per beat; 0 treated as 1
tone_o  out  1  tone square wave -> effects clk1
lfo_o  out  1  tremolo LFO -> effects clk2
octave_dena_o  out  1  octave-down enable
octave_uena_o  out  1  octave-up enable
tremolo_ena_o  out  1  tremolo enable
busy  out  1  high in LOAD/PLAY
step_o  out  ADDR_W  current step index
done  out  1  one-cycle pulse at end of non-looped playback

Behaviour:
- Reset: state IDLE; all table entries 0; step_o=0; tone_o, lfo_o, all enables, busy, done = 0. All outputs registered.
- Table write:
  - On wr_en, table[wr_addr] <= wr_data at the next edge; legal in any state.
  - A write to the entry currently playing does not affect it; it takes effect the next time that step is LOADed.
- States: IDLE, LOAD, PLAY, DONE.
- IDLE:
  - start (and not stop) -> LOAD with step=0.
  - busy=1 from the next cycle.
- LOAD (exactly 1 cycle):
  - Latch table[step] into current div/effect/dur.
  - Clear tone counter, beat counter, beat count, lfo counter.
  - tone_o=0, lfo_o=0, enables=0.
  - -> PLAY.
- PLAY:
  - Tone: if div=0 (rest), tone_o held 0. Otherwise tone counter increments each cycle; at count div-1, tone_o toggles and the counter clears. Half-period = div cycles; first toggle occurs div cycles after PLAY entry.
  - LFO: same scheme with TREM_DIV; free-running during PLAY, restarts at each LOAD.
  - Enables: registered decode of the current effect, high for the whole PLAY. With div=0, all enables are 0.
  - Beat counting: beat counter wraps at max(beat_len,1)-1 and increments beat count.
  - Step end: on the wrap where beat count == dur, the step ends. PLAY therefore lasts exactly (dur+1)*max(beat_len,1) cycles; a step occupies that plus 1 LOAD cycle.
  - After step end, if step < STEPS-1: step++ -> LOAD.
  - After step end, if step == STEPS-1 and loop_en=1: step=0 -> LOAD.
  - After step end, if step == STEPS-1 and loop_en=0: -> DONE.
  - beat_len and loop_en are sampled live, not latched.
- DONE (1 cycle):
  - done=1, busy=0, all outputs 0, step_o=0.
  - -> IDLE.
- stop:
  - In LOAD or PLAY: -> IDLE next edge.
  - All outputs 0 and step_o=0 on that same edge; no done pulse.
  - stop in IDLE/DONE has no effect.
- Simultaneous events:
  - start+stop in the same cycle: stop wins.
  - start while busy or in DONE: ignored.
  - wr_en coincident with LOAD of the same address: LOAD takes the old value.
- Reset mid-playback: immediate return to reset values at the next edge, table cleared.

Test Plan:
- Reset, write table[0]={div=3,eff=00,dur=0}, beat_len=12, others zero, loop_en=0, start -> busy high 1 cycle after start; tone_o toggles every 3 cycles (period 6) for 12 PLAY cycles; steps 1..7 are rests of 12 cycles each plus LOAD; done pulses once; total busy = 8*13 = 104 cycles.
- table[2]={div=5,eff=11,dur=1}, beat_len=4 -> at step 2, tremolo_ena_o=1 for exactly 8 cycles; lfo_o first toggles 64 cycles after PLAY entry (not reached); octave enables stay 0.
- Effects 01 and 10 on steps 0/1 -> octave_dena_o high only during step-0 PLAY, octave_uena_o high only during step-1 PLAY; both 0 in every LOAD cycle.
- loop_en=1, beat_len=0 -> each step PLAY lasts 1 cycle (dur=0); step_o sequence 0..7,0..; done never asserts; stop mid-PLAY -> busy, enables, tone_o all 0 next cycle, no done.
- start and stop asserted together in IDLE -> stays IDLE, busy=0; a second start during PLAY -> step_o sequence unchanged.
- Rewrite table[3] while step 3 plays -> the current step keeps its old div; the new div is heard on the next loop pass. Assert rst mid-PLAY -> all outputs 0 next cycle, and table[3] reads back as a rest on the next run.
